uart_rx: RTL and testbench

- Receive-side counterpart of the team's 16x-oversampled UART transmitter: recovers 8N1 frames (start, 8 data bits LSB first, stop) from the serial line.
- Presents each byte on a parallel output with a one-cycle valid pulse and flags framing errors.
- Carries the same 8-bit DFT scan-chain port set as the transmitter so both blocks stitch into one chain.

---
 rtl/uart_rx.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1 serial receiver with framing-error flag and an 8-bit DFT scan chain.
// Define UART_RX_PARITY_EN to add an even-parity bit (PARITY state) and the parity_err output.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy,
  output logic [2:0] state,
  input  logic       scan_enable,
  input  logic       scan_in,
  output logic       scan_out
);

  // Output handshake: data_valid is a one-cycle strobe with no ready/back-pressure;
  // the consumer takes data_out in the cycle data_valid is high (data_out holds afterwards).

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] H_CNT = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] L_CNT = BW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [2:0]             state_next;
  logic [BW-1:0]          baud_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_reg;
  logic [7:0]             scan_chain;
  logic                   mid_hit;
  logic                   end_hit;
  logic                   cnt_run;
  logic                   cnt_wrap;
  logic                   start_ok;
  logic                   data_smp;
  logic                   stop_smp;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bit;
  logic                   par_smp;
`endif

  // Synchronizer presets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign mid_hit = (baud_cnt == H_CNT);
  assign end_hit = (baud_cnt == L_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!scan_enable) begin
      case (state)
        S_IDLE:  if (!rx_s) state_next = S_START;
        S_START: if (mid_hit) state_next = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
        S_DATA:   if (end_hit && bit_cnt == 3'd7) state_next = S_PARITY;
        S_PARITY: if (end_hit) state_next = S_STOP;
`else
        S_DATA:  if (end_hit && bit_cnt == 3'd7) state_next = S_STOP;
`endif
        S_STOP:  if (end_hit) state_next = S_DONE;
        S_DONE:  if (rx_s) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != S_IDLE);
    cnt_run  = 1'b0;
    cnt_wrap = 1'b0;
    start_ok = 1'b0;
    data_smp = 1'b0;
    stop_smp = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_smp  = 1'b0;
`endif
    case (state)
      S_START: begin
        cnt_run  = 1'b1;
        cnt_wrap = mid_hit;
        start_ok = mid_hit && !rx_s;
      end
      S_DATA: begin
        cnt_run  = 1'b1;
        cnt_wrap = end_hit;
        data_smp = end_hit;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        cnt_run  = 1'b1;
        cnt_wrap = end_hit;
        par_smp  = end_hit;
      end
`endif
      S_STOP: begin
        cnt_run  = 1'b1;
        cnt_wrap = end_hit;
        stop_smp = end_hit;
      end
      default: ;
    endcase
  end

  // While scanning, the whole datapath freezes and the strobes are suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else if (scan_enable) begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (cnt_run && !cnt_wrap) begin
        baud_cnt <= baud_cnt + BW'(1);
      end else begin
        baud_cnt <= '0;
      end
      if (start_ok) begin
        bit_cnt <= '0;
      end
      if (data_smp) begin
        shift_reg[bit_cnt] <= rx_s;
        if (bit_cnt != 3'd7) begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      if (par_smp) begin
        parity_bit <= rx_s;
      end
      if (stop_smp) begin
        if (!rx_s) begin
          frame_err <= 1'b1;
        end else if (^{shift_reg, parity_bit}) begin
          parity_err <= 1'b1;
        end else begin
          data_out   <= shift_reg;
          data_valid <= 1'b1;
        end
      end
`else
      if (stop_smp) begin
        if (rx_s) begin
          data_out   <= shift_reg;
          data_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_chain <= '0;
    end else if (scan_enable) begin
      scan_chain <= {scan_chain[6:0], scan_in};
    end
  end

  assign scan_out = scan_chain[7];

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and checks pulses/data against a frame-level model.
// Frame timing follows UART_RX_PARITY_EN when that macro is defined.
module tb_uart_rx;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT       = 171;
  localparam int FRAME_CYC = 176;
`else
  localparam int LAT       = 155;
  localparam int FRAME_CYC = 160;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif
  logic       busy;
  logic [2:0] state;
  logic       scan_enable;
  logic       scan_in;
  logic       scan_out;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy), .state(state),
    .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_valid_cyc = -1;
  int n_ferr = 0;

  // Model: one entry per frame sent -- byte, expected pulse cycle, kind (1 = framing error).
  logic [7:0] exp_q[$];
  int         exp_t_q[$];
  bit         exp_k_q[$];
  logic [7:0] model_dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Called right after a negedge; the next posedge captures the start bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_good);
    exp_q.push_back(b);
    exp_t_q.push_back(cyc + LAT);
    exp_k_q.push_back(!stop_good);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^b;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_good;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    bit ev, ef, now;
    model_dout = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        model_dout = '0;
        exp_q.delete();
        exp_t_q.delete();
        exp_k_q.delete();
      end
      while (exp_t_q.size() > 0 && exp_t_q[0] < cyc) begin
        void'(exp_q.pop_front());
        void'(exp_t_q.pop_front());
        void'(exp_k_q.pop_front());
      end
      now = (exp_t_q.size() > 0) && (exp_t_q[0] == cyc);
      ev  = now && !exp_k_q[0];
      ef  = now && exp_k_q[0];
      if (ev) model_dout = exp_q[0];
      check("data_valid", {31'd0, data_valid}, {31'd0, ev});
      check("frame_err", {31'd0, frame_err}, {31'd0, ef});
      check("data_out", {24'd0, data_out}, {24'd0, model_dout});
`ifdef UART_RX_PARITY_EN
      check("parity_err", {31'd0, parity_err}, 32'd0);
`endif
      if (data_valid === 1'b1) last_valid_cyc = cyc;
      if (frame_err === 1'b1) n_ferr++;
      if (now) begin
        void'(exp_q.pop_front());
        void'(exp_t_q.pop_front());
        void'(exp_k_q.pop_front());
      end
    end
  end

  initial begin
    int s, t1, nf;
    logic [7:0] b;
    logic [7:0] scan_bits;
    bit good;
    rst = 1'b1;
    rx = 1'b1;
    scan_enable = 1'b0;
    scan_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_scan_out", {31'd0, scan_out}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single good frame
    s = cyc;
    send_frame(8'hA5, 1'b1);
    check("a5_latency", last_valid_cyc - s, LAT);
    check("a5_data", {24'd0, data_out}, 32'h0000_00A5);
    repeat (3) @(negedge clk);
    check("a5_busy_low", {31'd0, busy}, 32'd0);

    // Back-to-back frames
    send_frame(8'h3C, 1'b1);
    t1 = last_valid_cyc;
    check("b2b_first", {24'd0, data_out}, 32'h0000_003C);
    send_frame(8'hC3, 1'b1);
    check("b2b_spacing", last_valid_cyc - t1, FRAME_CYC);
    check("b2b_second", {24'd0, data_out}, 32'h0000_00C3);
    repeat (5) @(negedge clk);

    // Short glitch aborts in START
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_in_start", {29'd0, state}, 32'd1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_idle", {29'd0, state}, 32'd0);
    check("glitch_data", {24'd0, data_out}, 32'h0000_00C3);

    // Bad stop bit followed by a long break
    nf = n_ferr;
    send_frame(8'h55, 1'b0);
    repeat (150) @(negedge clk);
    check("break_done", {29'd0, state}, 32'd4);
    check("break_busy", {31'd0, busy}, 32'd1);
    repeat (150) @(negedge clk);
    check("break_one_ferr", n_ferr - nf, 1);
    check("break_data_kept", {24'd0, data_out}, 32'h0000_00C3);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("break_release", {29'd0, state}, 32'd0);

    // Reset at edge 60 of a 0xFF frame
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (60 - CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state", {29'd0, state}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_data", {24'd0, data_out}, 32'd0);
    check("midrst_valid", {31'd0, data_valid}, 32'd0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    send_frame(8'h12, 1'b1);
    check("after_rst_data", {24'd0, data_out}, 32'h0000_0012);
    repeat (5) @(negedge clk);

    // Scan shift while idle
    scan_bits = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      scan_enable = 1'b1;
      scan_in = scan_bits[7 - i];
      @(negedge clk);
      check("scan_state_held", {29'd0, state}, 32'd0);
    end
    check("scan_first_bit", {31'd0, scan_out}, 32'd1);
    for (int i = 1; i < 8; i++) begin
      scan_in = 1'b0;
      @(negedge clk);
      check("scan_shift_out", {31'd0, scan_out}, {31'd0, scan_bits[7 - i]});
    end
    scan_enable = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized frames, mostly good, with random gaps (zero gap = back-to-back)
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 9) != 0);
      send_frame(b, good);
      rx = 1'b1;
      repeat (good ? $urandom_range(0, 12) : $urandom_range(2, 12)) @(negedge clk);
    end
    rx = 1'b1;
    repeat (LAT + 10) @(negedge clk);
    check("model_drained", exp_t_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
